regwrite_arbiter: RTL and testbench

- Sits directly upstream of the register file and merges its two write sources into one registered write port.
- Source A is the pipeline MEM/WB writeback; source B is the LAA core-register write stream.
- LAA writes are buffered in a small FIFO and drained in cycles the pipeline does not write. A starvation limit and a same-register ordering rule force draining, stalling writeback when needed.
- Also flags decode-stage reads of registers that still have queued LAA writes.

---
 rtl/regwrite_arbiter.sv | 172 +++++++++++++++++
 tb/tb_regwrite_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_arbiter.sv
// Merges MEM/WB writeback and the LAA core-register write stream into one registered register-file write port.
// Latency: the selected write appears on rf_we/rf_rd/rf_wdata one clk after selection; an LAA entry waits >=1 cycle in the FIFO.
// Backpressure: laa_ready drops while the FIFO is full; stall_wb holds MEM/WB when the FIFO head must drain first.
module regwrite_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        Rst_n,
    // MEM/WB writeback source
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_wb,
    // LAA write stream
    input  logic        laa_valid,
    output logic        laa_ready,
    input  logic [4:0]  laa_rd,
    input  logic [31:0] laa_data,
    // decode-stage hazard lookup
    input  logic [4:0]  adr_rs1,
    input  logic [4:0]  adr_rs2,
    output logic        pend_rs1,
    output logic        pend_rs2,
    // register-file write port
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
    localparam logic [AW:0]   OCC_FULL   = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } laa_ent_t;

    // FIFO storage and pointers; the extra pointer bit separates full from empty
    laa_ent_t          fifo_mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       occ;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DEPTH-1:0]  ent_vld;
    logic [AW-1:0]     slot_off;
    laa_ent_t          head_ent;

    // arbitration state and decisions
    logic [SW-1:0]     starve_cnt;
    logic              init_done;
    logic              wb_vld;
    logic              wb_hit;
    logic              starved;
    logic              force_drain;
    logic              do_pop;
    logic              do_wb;
    logic              do_push;
    logic              pend1_hit;
    logic              pend2_hit;

    assign occ        = wr_ptr - rd_ptr;
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == OCC_FULL);
    assign head_ent   = fifo_mem[rd_ptr[AW-1:0]];

    // init_done keeps laa_ready low until the first clock after reset release
    assign laa_ready = init_done & ~fifo_full;

    // x0 writes from LAA are accepted but never occupy a slot
    assign do_push = laa_valid & laa_ready & (laa_rd != 5'd0);

    // wb writes to x0 are ignored entirely
    assign wb_vld = wb_regwrite & (wb_rd != 5'd0);

    // Mark which physical slots hold live entries (offset from head below occupancy)
    always_comb begin
        ent_vld  = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off   = AW'(i) - rd_ptr[AW-1:0];
            ent_vld[i] = ({1'b0, slot_off} < occ);
        end
    end

    // Compare queued destinations against the wb target and both decode read ports
    always_comb begin
        wb_hit    = 1'b0;
        pend1_hit = 1'b0;
        pend2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                if (fifo_mem[i].rd == wb_rd)   wb_hit    = 1'b1;
                if (fifo_mem[i].rd == adr_rs1) pend1_hit = 1'b1;
                if (fifo_mem[i].rd == adr_rs2) pend2_hit = 1'b1;
            end
        end
    end

    // An entry popped this cycle still reports pending: it lands in the regfile next cycle
    assign pend_rs1 = (adr_rs1 != 5'd0) & pend1_hit;
    assign pend_rs2 = (adr_rs2 != 5'd0) & pend2_hit;

    // Head must go first when it has waited too long or an older queued write targets the same rd
    assign starved     = ~fifo_empty & (starve_cnt == STARVE_MAX);
    assign force_drain = starved | (wb_vld & wb_hit);

    // One write per cycle: wb wins unless a drain is forced; idle wb cycles drain the FIFO
    assign do_pop   = ~fifo_empty & (~wb_vld | force_drain);
    assign do_wb    = wb_vld & ~force_drain;
    assign stall_wb = wb_vld & force_drain;

    // Reset release tracker for laa_ready
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // FIFO pointer update; push and pop may coincide on a non-full FIFO
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // FIFO payload storage; contents are don't-care until covered by the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= '{rd: laa_rd, dat: laa_data};
        end
    end

    // Count how long the head has waited without being popped, saturating at the force threshold
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            starve_cnt <= '0;
        end else if (do_pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Register the selected write; address and data hold when no write is issued
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_we <= do_pop | do_wb;
            if (do_pop) begin
                rf_rd    <= head_ent.rd;
                rf_wdata <= head_ent.dat;
            end else if (do_wb) begin
                rf_rd    <= wb_rd;
                rf_wdata <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Testbench for regwrite_arbiter: table vectors, hand-written corner sequences and a random run vs a queue model.
// Latency: inputs change 1 time unit after posedge; outputs are compared on the following negedge.
// Backpressure: LAA pushes follow the model's ready; stalled wb requests are simply re-presented by the stimulus.
module tb_regwrite_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        Rst_n;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_wb;
    logic        laa_valid;
    logic        laa_ready;
    logic [4:0]  laa_rd;
    logic [31:0] laa_data;
    logic [4:0]  adr_rs1;
    logic [4:0]  adr_rs2;
    logic        pend_rs1;
    logic        pend_rs2;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    regwrite_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk        (clk),
        .Rst_n      (Rst_n),
        .wb_regwrite(wb_regwrite),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .stall_wb   (stall_wb),
        .laa_valid  (laa_valid),
        .laa_ready  (laa_ready),
        .laa_rd     (laa_rd),
        .laa_data   (laa_data),
        .adr_rs1    (adr_rs1),
        .adr_rs2    (adr_rs2),
        .pend_rs1   (pend_rs1),
        .pend_rs2   (pend_rs2),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata)
    );

    // ---------------- reference model: a plain queue of pending LAA writes ----------------
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } ent_t;

    ent_t        mq[$];
    int          m_wait;
    bit          m_live;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_dat;
    logic [31:0] m_regs [32];
    logic [31:0] d_regs [32];
    bit          e_stall, e_ready, e_p1, e_p2, e_pop, e_take;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit queued(input logic [4:0] r);
        foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wait = 0;
        m_live = 1'b0;
        m_we   = 1'b0;
        m_rd   = 5'd0;
        m_dat  = 32'd0;
    endtask

    task automatic model_eval();
        bit wbv, frc;
        wbv     = wb_regwrite && (wb_rd != 5'd0);
        frc     = (mq.size() > 0 && m_wait == STARVE_LIMIT - 1) || (wbv && queued(wb_rd));
        e_stall = wbv && frc;
        e_ready = m_live && (mq.size() < DEPTH);
        e_p1    = (adr_rs1 != 5'd0) && queued(adr_rs1);
        e_p2    = (adr_rs2 != 5'd0) && queued(adr_rs2);
        e_pop   = (mq.size() > 0) && (!wbv || frc);
        e_take  = wbv && !frc;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model at mid-cycle
    task automatic step_check();
        @(negedge clk);
        model_eval();
        chk("stall_wb",  {31'd0, stall_wb},  {31'd0, e_stall});
        chk("laa_ready", {31'd0, laa_ready}, {31'd0, e_ready});
        chk("pend_rs1",  {31'd0, pend_rs1},  {31'd0, e_p1});
        chk("pend_rs2",  {31'd0, pend_rs2},  {31'd0, e_p2});
        chk("rf_we",     {31'd0, rf_we},     {31'd0, m_we});
        chk("rf_rd",     {27'd0, rf_rd},     {27'd0, m_rd});
        chk("rf_wdata",  rf_wdata,           m_dat);
        if (rf_we === 1'b1) d_regs[rf_rd] = rf_wdata;
    endtask

    // Advance the model by one cycle and move to just after the next posedge
    task automatic step_adv();
        int occ0;
        model_eval();
        occ0 = mq.size();
        if (e_pop) begin
            m_we  = 1'b1;
            m_rd  = mq[0].rd;
            m_dat = mq[0].dat;
            void'(mq.pop_front());
        end else if (e_take) begin
            m_we  = 1'b1;
            m_rd  = wb_rd;
            m_dat = wb_data;
        end else begin
            m_we = 1'b0;
        end
        if (m_we) m_regs[m_rd] = m_dat;
        if (e_pop || occ0 == 0) m_wait = 0;
        else if (m_wait < STARVE_LIMIT - 1) m_wait++;
        if (laa_valid && e_ready && laa_rd != 5'd0) mq.push_back('{rd: laa_rd, dat: laa_data});
        m_live = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        step_check();
        step_adv();
    endtask

    task automatic idle_inputs();
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        laa_valid = 1'b0; laa_rd = 5'd0; laa_data = 32'd0;
        adr_rs1 = 5'd0; adr_rs2 = 5'd0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        x_stall;
        logic        x_ready;
        logic        x_p1;
        logic        x_p2;
        logic        x_we;
        logic [4:0]  x_rd;
        logic [31:0] x_dat;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int got_rd[$];
        int nacc;
        int cnt;
        logic [31:0] r4;

        // wv wrd wdat           lv lrd ldat    rs1 rs2 | stall rdy p1 p2 we rd  dat
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h11, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h11};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'hA,  5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h11};
        tbl[7]  = '{1'b1, 5'd4, 32'hB,        1'b0, 5'd0, 32'h0,  5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h11};
        tbl[8]  = '{1'b1, 5'd4, 32'hB,        1'b0, 5'd0, 32'h0,  5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'hA};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'hB};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'hB};

        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            d_regs[i] = 32'd0;
        end

        // ---- reset state ----
        Rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        chk("reset.rf_we",     {31'd0, rf_we},     32'd0);
        chk("reset.rf_rd",     {27'd0, rf_rd},     32'd0);
        chk("reset.rf_wdata",  rf_wdata,           32'd0);
        chk("reset.laa_ready", {31'd0, laa_ready}, 32'd0);
        chk("reset.stall_wb",  {31'd0, stall_wb},  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        Rst_n = 1'b1;
        step();

        // ---- table vectors: wb write, LAA drain with pending flag, same-register ordering ----
        for (int k = 0; k < 11; k++) begin
            wb_regwrite = tbl[k].wv;  wb_rd  = tbl[k].wrd; wb_data  = tbl[k].wdat;
            laa_valid   = tbl[k].lv;  laa_rd = tbl[k].lrd; laa_data = tbl[k].ldat;
            adr_rs1     = tbl[k].rs1; adr_rs2 = tbl[k].rs2;
            step_check();
            chk($sformatf("vec%0d.stall", k), {31'd0, stall_wb},  {31'd0, tbl[k].x_stall});
            chk($sformatf("vec%0d.ready", k), {31'd0, laa_ready}, {31'd0, tbl[k].x_ready});
            chk($sformatf("vec%0d.pend1", k), {31'd0, pend_rs1},  {31'd0, tbl[k].x_p1});
            chk($sformatf("vec%0d.pend2", k), {31'd0, pend_rs2},  {31'd0, tbl[k].x_p2});
            chk($sformatf("vec%0d.we", k),    {31'd0, rf_we},     {31'd0, tbl[k].x_we});
            chk($sformatf("vec%0d.rd", k),    {27'd0, rf_rd},     {27'd0, tbl[k].x_rd});
            chk($sformatf("vec%0d.data", k),  rf_wdata,           tbl[k].x_dat);
            step_adv();
        end
        r4 = d_regs[4];
        chk("ordering.x4_final", r4, 32'hB);

        // ---- starvation: rd9 queued while wb to rd3 is held ----
        idle_inputs();
        laa_valid = 1'b1; laa_rd = 5'd9; laa_data = 32'h99;
        step();
        idle_inputs();
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        for (int k = 1; k <= 8; k++) begin
            step_check();
            chk($sformatf("starve.stall_c%0d", k), {31'd0, stall_wb}, (k == 8) ? 32'd1 : 32'd0);
            step_adv();
        end
        step_check();
        chk("starve.drain_we", {31'd0, rf_we}, 32'd1);
        chk("starve.drain_rd", {27'd0, rf_rd}, 32'd9);
        chk("starve.drain_dat", rf_wdata, 32'h99);
        chk("starve.stall_after", {31'd0, stall_wb}, 32'd0);
        step_adv();
        step_check();
        chk("starve.wb_rd", {27'd0, rf_rd}, 32'd3);
        chk("starve.wb_we", {31'd0, rf_we}, 32'd1);
        idle_inputs();
        step_adv();

        // ---- overfill: 5 LAA writes against continuous wb traffic ----
        nacc = 0;
        wb_regwrite = 1'b1; wb_rd = 5'd30; wb_data = 32'h300;
        for (int c = 0; c < 60; c++) begin
            if (nacc < 5) begin
                laa_valid = 1'b1;
                laa_rd    = 5'(10 + nacc);
                laa_data  = 32'h100 + 32'(nacc);
            end else begin
                laa_valid = 1'b0;
            end
            step_check();
            if (c == 4) chk("fill.ready_after_4", {31'd0, laa_ready}, 32'd0);
            if (c == 8) begin
                chk("fill.ready_c8", {31'd0, laa_ready}, 32'd0);
                chk("fill.stall_c8", {31'd0, stall_wb},  32'd1);
            end
            if (c == 9) chk("fill.ready_c9", {31'd0, laa_ready}, 32'd1);
            if (rf_we === 1'b1 && rf_rd >= 5'd10 && rf_rd <= 5'd14) got_rd.push_back(int'(rf_rd));
            if (laa_valid && e_ready) nacc++;
            step_adv();
        end
        chk("fill.count", 32'(got_rd.size()), 32'd5);
        foreach (got_rd[i]) chk($sformatf("fill.order%0d", i), 32'(got_rd[i]), 32'(10 + i));

        // ---- reset with three entries queued ----
        wb_regwrite = 1'b1; wb_rd = 5'd30; wb_data = 32'h300;
        for (int k = 0; k < 3; k++) begin
            laa_valid = 1'b1; laa_rd = 5'(15 + k); laa_data = 32'h500 + 32'(k);
            step();
        end
        idle_inputs();
        Rst_n = 1'b0;
        #1;
        chk("midreset.rf_we",     {31'd0, rf_we},     32'd0);
        chk("midreset.rf_rd",     {27'd0, rf_rd},     32'd0);
        chk("midreset.rf_wdata",  rf_wdata,           32'd0);
        chk("midreset.laa_ready", {31'd0, laa_ready}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        Rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step_check();
            if (rf_we === 1'b1) cnt++;
            step_adv();
        end
        chk("midreset.no_writes", 32'(cnt), 32'd0);

        // ---- random traffic against the model ----
        for (int c = 0; c < 600; c++) begin
            if (c < 300) wb_regwrite = 1'($urandom_range(0, 1));
            else         wb_regwrite = ($urandom_range(0, 9) != 0);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            laa_valid = 1'($urandom_range(0, 1));
            laa_rd    = 5'($urandom_range(0, 7));
            laa_data  = $urandom;
            adr_rs1   = 5'($urandom_range(0, 7));
            adr_rs2   = 5'($urandom_range(0, 7));
            step();
        end
        idle_inputs();
        for (int k = 0; k < 40; k++) step();

        for (int i = 0; i < 32; i++) chk($sformatf("regfile.x%0d", i), d_regs[i], m_regs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
